// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: ALU results take the write port first,
// LSU results queue in a small FIFO, and a pending-register scoreboard tracks loads in flight.
module regfile_wb_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [4:0]      r_fifo_rd [DEPTH];
    logic [XLEN-1:0] r_fifo_wd [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [31:0]     r_pending;
    logic            r_we3;
    logic [4:0]      r_a3;
    logic [XLEN-1:0] r_wd3;

    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_wd;

    assign lsu_ready = !reset && (r_count != CNT_FULL);
    assign w_push    = lsu_valid && lsu_ready;
    // The ALU owns the port whenever it has a result; the FIFO only drains in ALU-idle cycles.
    assign w_pop     = !alu_valid && (r_count != '0);
    assign w_head_rd = r_fifo_rd[r_rptr];
    assign w_head_wd = r_fifo_wd[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr] <= lsu_rd;
            r_fifo_wd[r_wptr] <= lsu_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (alu_valid) begin
            r_we3 <= (alu_rd != '0);
            r_a3  <= alu_rd;
            r_wd3 <= alu_wd;
        end else if (w_pop) begin
            r_we3 <= (w_head_rd != '0);
            r_a3  <= w_head_rd;
            r_wd3 <= w_head_wd;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // Clear is written before set so a same-cycle issue to the popped register keeps it pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            if (w_pop && (w_head_rd != '0)) r_pending[w_head_rd] <= 1'b0;
            if (iss_valid && (iss_rd != '0)) r_pending[iss_rd] <= 1'b1;
        end
    end

    assign rs1_busy = r_pending[rs1] && (rs1 != '0);
    assign rs2_busy = r_pending[rs2] && (rs2 != '0);
    assign we3      = r_we3;
    assign a3       = r_a3;
    assign wd3      = r_wd3;

endmodule
